tim_cfg_sequencer: RTL
======================

# tim_cfg_sequencer

APB-master configuration sequencer for the advanced timer (`apoip_timer`). A small, software-loaded command table holds write, read and wait operations. On `start`, the block replays the table as back-to-back two-phase APB transfers on the timer slave port. Typical use: the standard PWM bring-up (ARR, CCR1, DIER, CCMR1, EGR, CCER, BDTR, CR1) and mid-run reconfiguration, with no CPU involvement.

## Interface
Parameters:
- DEPTH, 16, number of table entries (power of two, ≤256)
- IDX_W, 4, log2(DEPTH)

Ports:
- apb_clk  in  1  clock; all state updates on rising edge
- apb_rst  in  1  asynchronous, active-high reset
- tbl_we  in  1  table write strobe; ignored while busy
- tbl_idx  in  IDX_W  entry index to write
- tbl_op  in  2  opcode: 00 write, 01 read, 10 wait, 11 end
- tbl_addr  in  16  APB address for the entry
- tbl_data  in  32  write data; for wait, bits[15:0] are the cycle count
- start  in  1  one-cycle pulse; begins sequence at entry 0
- num_entries  in  IDX_W+1  entries to run, sampled with start; 0..DEPTH
- abort  in  1  request early stop
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort completion
- rd_valid  out  1  one-cycle pulse: read data available
- rd_idx  out  IDX_W  table index of the read
- rd_data  out  32  captured timx_prdata
- timx_psel  out  1  APB select
- timx_penable  out  1  APB enable
- timx_pwrite  out  1  APB direction
- timx_paddr  out  16  APB address
- timx_pwdata  out  32  APB write data
- timx_prdata  in  32  APB read data

## Operation
- Table: DEPTH × {op[1:0], addr[15:0], data[31:0]} flops. Contents are not cleared by reset; no read port.
- FSM states: IDLE, SETUP, ACCESS, WAIT, DONE.
- IDLE
  - `start` with num_entries=0 → DONE.
  - Otherwise `start` sets ptr=0, latches the count, and dispatches entry 0.
- Dispatch of entry ptr:
  - op 00/01 → SETUP.
  - op 10 → WAIT; cnt=max(data[15:0],1).
  - op 11 → DONE. End terminates the sequence early.
- SETUP: psel=1, penable=0; paddr, pwrite and pwdata driven from the entry. pwdata is 0 for reads.
- ACCESS: psel=1, penable=1; same addr and data. The timer has no pready, so ACCESS is always exactly one cycle.
  - On exit, a read captures timx_prdata into rd_data.
  - Then ptr+1: if ptr+1 == count → DONE, else dispatch next.
- WAIT: psel=0; cnt decrements each cycle. On reaching 1, advance as for ACCESS exit.
- DONE: done=1 for one cycle (or aborted=1 if abort was pending) → IDLE.
- abort:
  - Sampled in any non-IDLE state.
  - In SETUP it is held pending, and ACCESS still completes. A transfer is never truncated.
  - In ACCESS, on exit, go to DONE instead of advancing.
  - In WAIT, go to DONE next cycle.
  - Ignored in IDLE.
- `start` while busy: ignored. `tbl_we` while busy: ignored.
- Reset: all outputs 0, FSM IDLE, ptr/cnt 0; takes effect immediately, mid-transfer included.

## Timing
- `start` sampled at edge 0 → SETUP in cycle 1, ACCESS in cycle 2, next SETUP in cycle 3. There are no idle cycles between transfers.
- N writes: busy for 2N+1 cycles; done in cycle 2N+1.
- Read: rd_valid, rd_idx and rd_data are valid in the cycle after the ACCESS cycle; rd_data holds until the next read.
- Wait with count W: psel low for W cycles (W=0 treated as 1).
- num_entries=0: busy and done both high in cycle 1, with no APB activity.
- All outputs are registered (no combinational input→output paths).
- paddr and pwdata are stable across SETUP and ACCESS; psel drops in the cycle after ACCESS unless another transfer follows.

## Test plan
- **PWM init script.** Load 8 writes: 002C←8, 0034←7, 000C←20, 0018←68, 0014←1, 0020←5, 0044←8C00, 0000←81; start with num_entries=8.
  - Required: exactly 8 SETUP/ACCESS pairs in order, back-to-back, with correct addr/data.
  - Required: done in cycle 17; timer ch1 PWM toggles with period 9.
- **Read op.** Entry 0 is read 0010 with the slave returning 0x0000_0003.
  - Required: rd_valid in cycle 3, rd_idx=0, rd_data=3, pwrite=0, pwdata=0.
- **Wait/end.** Entries write 0018←48, wait 5, write 0020←1, end, write 0014←20; num_entries=5.
  - Required: gap of 5 psel-low cycles between the two writes.
  - Required: done right after the second write; 0014 is never accessed.
- **Abort.** Assert abort during the SETUP of the 3rd write.
  - Required: that transfer completes, then aborted pulses, done never pulses, and no 4th transfer occurs.
- **Boundaries.**
  - num_entries=0 → done in cycle 1, with no APB activity.
  - num_entries=DEPTH (16) runs all entries.
  - start and tbl_we while busy have no effect: the table is unchanged on rerun.
- **Reset mid-op.** Assert apb_rst during ACCESS.
  - Required: psel, penable and busy drop asynchronously, the FSM is in IDLE after release, and a new start runs from entry 0.

Source files
------------

// File: rtl/tim_cfg_sequencer_if.sv
// APB bus between the configuration sequencer (master) and the timer slave port.
// Signal names follow the timer's timx_* port naming.
interface tim_cfg_sequencer_if;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;

  modport master (
    output timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    input  timx_prdata
  );

  modport slave (
    input  timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    output timx_prdata
  );
endinterface

// File: rtl/tim_cfg_sequencer.sv
// Replays a software-loaded table of write/read/wait/end commands as back-to-back
// two-phase APB transfers on the timer slave port.
module tim_cfg_sequencer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic               apb_clk,
  input  logic               apb_rst,
  input  logic               tbl_we,
  input  logic [IDX_W-1:0]   tbl_idx,
  input  logic [1:0]         tbl_op,
  input  logic [15:0]        tbl_addr,
  input  logic [31:0]        tbl_data,
  input  logic               start,
  input  logic [IDX_W:0]     num_entries,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               rd_valid,
  output logic [IDX_W-1:0]   rd_idx,
  output logic [31:0]        rd_data,
  tim_cfg_sequencer_if.master timx
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam logic [IDX_W:0] CNT_ZERO = '0;
  localparam logic [IDX_W:0] CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W:0]   count_reg, count_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             busy_reg, done_reg, aborted_reg, rd_valid_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic [31:0]      rd_data_reg;
  logic             psel_reg, penable_reg, pwrite_reg;
  logic [15:0]      paddr_reg;
  logic [31:0]      pwdata_reg;

  // Table entries: {op[49:48], addr[47:32], data[31:0]}, deliberately not reset.
  logic [DEPTH-1:0][49:0] ent_rd;
  logic                   tbl_wr_ok;

  assign tbl_wr_ok = (state_reg == ST_IDLE);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [49:0] ent_reg;
      always_ff @(posedge apb_clk) begin
        if (tbl_we && tbl_wr_ok && (tbl_idx == IDX_W'(gi))) begin
          ent_reg <= {tbl_op, tbl_addr, tbl_data};
        end
      end
      assign ent_rd[gi] = ent_reg;
    end
  endgenerate

  logic [IDX_W:0]   ptr_inc;
  logic [IDX_W-1:0] disp_idx;
  logic [49:0]      disp_ent;
  logic [1:0]       disp_op;
  logic [15:0]      disp_wait;

  assign ptr_inc   = {1'b0, ptr_reg} + CNT_ONE;
  assign disp_idx  = (state_reg == ST_IDLE) ? '0 : ptr_inc[IDX_W-1:0];
  assign disp_ent  = ent_rd[disp_idx];
  assign disp_op   = disp_ent[49:48];
  assign disp_wait = (disp_ent[15:0] == 16'd0) ? 16'd1 : disp_ent[15:0];

  logic dispatch, advance, abort_fin;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    dispatch   = 1'b0;
    advance    = 1'b0;
    abort_fin  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        pend_next = 1'b0;
        if (start) begin
          if (num_entries == CNT_ZERO) begin
            state_next = ST_DONE;
          end else begin
            count_next = num_entries;
            dispatch   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        // An abort here only arms; the transfer always finishes its ACCESS phase.
        state_next = ST_ACCESS;
        if (abort) pend_next = 1'b1;
      end
      ST_ACCESS: begin
        if (abort || pend_reg) begin
          state_next = ST_DONE;
          abort_fin  = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort || pend_reg) begin
          state_next = ST_DONE;
          abort_fin  = 1'b1;
        end else if (cnt_reg <= 16'd1) begin
          advance = 1'b1;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        pend_next  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase

    if (advance) begin
      if (ptr_inc == count_reg) state_next = ST_DONE;
      else                      dispatch   = 1'b1;
    end

    if (dispatch) begin
      ptr_next = disp_idx;
      case (disp_op)
        OP_WRITE, OP_READ: state_next = ST_SETUP;
        OP_WAIT: begin
          state_next = ST_WAIT;
          cnt_next   = disp_wait;
        end
        default: state_next = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      count_reg    <= '0;
      cnt_reg      <= '0;
      pend_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_idx_reg   <= '0;
      rd_data_reg  <= '0;
      psel_reg     <= 1'b0;
      penable_reg  <= 1'b0;
      pwrite_reg   <= 1'b0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      count_reg   <= count_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      busy_reg    <= (state_next != ST_IDLE);
      done_reg    <= (state_next == ST_DONE) && !abort_fin;
      aborted_reg <= (state_next == ST_DONE) && abort_fin;
      psel_reg    <= (state_next == ST_SETUP) || (state_next == ST_ACCESS);
      penable_reg <= (state_next == ST_ACCESS);
      if (state_next == ST_SETUP) begin
        paddr_reg  <= disp_ent[47:32];
        pwrite_reg <= (disp_op == OP_WRITE);
        pwdata_reg <= (disp_op == OP_WRITE) ? disp_ent[31:0] : 32'd0;
      end
      // Read data is captured at the end of ACCESS, abort or not.
      rd_valid_reg <= (state_reg == ST_ACCESS) && !pwrite_reg;
      if ((state_reg == ST_ACCESS) && !pwrite_reg) begin
        rd_data_reg <= timx.timx_prdata;
        rd_idx_reg  <= ptr_reg;
      end
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign aborted           = aborted_reg;
  assign rd_valid          = rd_valid_reg;
  assign rd_idx            = rd_idx_reg;
  assign rd_data           = rd_data_reg;
  assign timx.timx_psel    = psel_reg;
  assign timx.timx_penable = penable_reg;
  assign timx.timx_pwrite  = pwrite_reg;
  assign timx.timx_paddr   = paddr_reg;
  assign timx.timx_pwdata  = pwdata_reg;

endmodule
